// File: rtl/rdout_sched_if.sv
// Handshake and status bundle between the event readout scheduler and its sources.
// Source bit map on every 7-bit vector: [7]=ALCT, [6]=TMB, [5:1]=CFEB5..1.
interface rdout_sched_if;
  logic       START;
  logic [7:1] ACT;
  logic [7:1] KILL;
  logic [7:1] RDY;
  logic       DONE;
  logic       BUSY;
  logic [7:1] GNT;
  logic       EVT_DONE;
  logic [7:1] NODATA;
  logic [7:1] NOEND;

  modport master (
    output START, ACT, KILL, RDY, DONE,
    input  BUSY, GNT, EVT_DONE, NODATA, NOEND
  );

  modport slave (
    input  START, ACT, KILL, RDY, DONE,
    output BUSY, GNT, EVT_DONE, NODATA, NOEND
  );
endinterface

// File: rtl/rdout_sched.sv
// Per-event readout scheduler: latches active sources, waits a bounded hold-off for data,
// then grants the shared output path one source at a time with a per-grant timeout.
module rdout_sched #(
  parameter int unsigned HLDOFF = 448,
  parameter int unsigned TMO_W  = 12
) (
  input  logic         CLKCMS,
  input  logic         pop_rst,
  rdout_sched_if.slave bus
);

  localparam int unsigned HC_W = (HLDOFF > 1) ? $clog2(HLDOFF) : 1;
  localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(HLDOFF - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = '1;

  typedef enum logic [2:0] {IDLE, HOLD, ARB, XFER, GAP, FIN} state_t;

  state_t           state_q, state_d;
  logic [7:1]       pend_q, pend_d;
  logic [HC_W-1:0]  hcnt_q, hcnt_d;
  logic [TMO_W-1:0] tcnt_q, tcnt_d;
  logic [7:1]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             evt_done_q, evt_done_d;
  logic [7:1]       nodata_q, nodata_d;
  logic [7:1]       noend_q, noend_d;
  logic [7:1]       missing;
  logic [TMO_W-1:0] tcnt_inc;

  // Fixed priority: ALCT, TMB, then CFEB1 up to CFEB5.
  function automatic logic [7:1] pick(input logic [7:1] p);
    logic [7:1] g;
    g = '0;
    if (p[7])      g[7] = 1'b1;
    else if (p[6]) g[6] = 1'b1;
    else begin
      for (int i = 1; i <= 5; i++) begin
        if (p[i] && (g == '0)) g[i] = 1'b1;
      end
    end
    return g;
  endfunction

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    hcnt_d     = hcnt_q;
    tcnt_d     = tcnt_q;
    gnt_d      = gnt_q;
    busy_d     = busy_q;
    evt_done_d = 1'b0;
    nodata_d   = nodata_q;
    noend_d    = noend_q;
    missing    = pend_q & ~bus.RDY;
    tcnt_inc   = tcnt_q + TMO_W'(1);

    unique case (state_q)
      IDLE: begin
        if (bus.START) begin
          pend_d   = bus.ACT & ~bus.KILL;
          nodata_d = '0;
          noend_d  = '0;
          hcnt_d   = '0;
          busy_d   = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (hcnt_q != HC_LAST) hcnt_d = hcnt_q + HC_W'(1);
        if ((missing == '0) || (hcnt_q == HC_LAST)) begin
          nodata_d = missing;
          pend_d   = pend_q & bus.RDY;
          state_d  = ARB;
        end
      end
      ARB: begin
        if (pend_q == '0) begin
          evt_done_d = 1'b1;
          state_d    = FIN;
        end else begin
          gnt_d   = pick(pend_q);
          tcnt_d  = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        // Timeout is judged on the incremented count so the counter tops out at all-ones and never wraps.
        tcnt_d = tcnt_inc;
        if (bus.DONE) begin
          pend_d  = pend_q & ~gnt_q;
          gnt_d   = '0;
          state_d = GAP;
        end else if (tcnt_inc == TMO_LAST) begin
          noend_d = noend_q | gnt_q;
          pend_d  = pend_q & ~gnt_q;
          gnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: state_d = ARB;
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLKCMS or posedge pop_rst) begin
    if (pop_rst) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      hcnt_q     <= '0;
      tcnt_q     <= '0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      evt_done_q <= 1'b0;
      nodata_q   <= '0;
      noend_q    <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      hcnt_q     <= hcnt_d;
      tcnt_q     <= tcnt_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      evt_done_q <= evt_done_d;
      nodata_q   <= nodata_d;
      noend_q    <= noend_d;
    end
  end

  assign bus.BUSY     = busy_q;
  assign bus.GNT      = gnt_q;
  assign bus.EVT_DONE = evt_done_q;
  assign bus.NODATA   = nodata_q;
  assign bus.NOEND    = noend_q;

endmodule

// File: tb/tb_rdout_sched.sv
// Bench for rdout_sched: event vectors from a table, grants and error words checked
// through a scoreboard, plus a hand sequence for START-while-busy and mid-event reset.
module tb_rdout_sched;

  typedef struct {
    logic [7:1] act;
    logic [7:1] kill;
    logic [7:1] rdy;
    int         done_at;   // grant cycle in which DONE is pulsed; 0 = never
    logic [7:1] nodata;
    logic [7:1] noend;
    int         len;       // cycles from START edge to the EVT_DONE cycle
  } vec_t;

  typedef struct {
    logic [7:1] nd;
    logic [7:1] ne;
  } err_t;

  logic clk;
  logic rst;
  rdout_sched_if bus();

  rdout_sched #(.HLDOFF(448), .TMO_W(12)) dut (
    .CLKCMS (clk),
    .pop_rst(rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:1] gnt_q[$];
  err_t       err_q[$];
  int         done_at = 0;
  int         last_len = 0;
  int         order[7] = '{7, 6, 1, 2, 3, 4, 5};
  vec_t       vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected grants and error words, drives DONE into the current grant.
  initial begin
    logic [7:1] prev_gnt;
    logic [7:1] eg;
    err_t       ee;
    int         gcyc;
    prev_gnt = '0;
    gcyc = 0;
    bus.DONE = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_gnt = '0;
        gcyc = 0;
        bus.DONE = 1'b0;
        continue;
      end
      if (bus.GNT != '0) begin
        if (bus.GNT != prev_gnt) begin
          if (prev_gnt != '0) chk("gap_before_gnt", 32'(prev_gnt), 32'h0);
          gcyc = 1;
          chk("gnt_onehot", 32'($onehot(bus.GNT)), 32'h1);
          if (gnt_q.size() == 0) chk("gnt_unexpected", 32'(bus.GNT), 32'h0);
          else begin
            eg = gnt_q.pop_front();
            chk("gnt_order", 32'(bus.GNT), 32'(eg));
          end
        end else begin
          gcyc++;
        end
      end else begin
        if (prev_gnt != '0) last_len = gcyc;
        gcyc = 0;
      end
      bus.DONE = (done_at != 0) && (gcyc == done_at);
      if (bus.EVT_DONE) begin
        if (err_q.size() == 0) chk("evt_done_unexpected", 32'h1, 32'h0);
        else begin
          ee = err_q.pop_front();
          chk("nodata", 32'(bus.NODATA), 32'(ee.nd));
          chk("noend", 32'(bus.NOEND), 32'(ee.ne));
        end
      end
      prev_gnt = bus.GNT;
    end
  end

  task automatic run_event(input int idx, input vec_t v);
    logic [7:1] elig;
    logic [7:1] g;
    err_t       ee;
    int         n;
    int         ngnt;
    bit         got;
    elig = v.act & ~v.kill & v.rdy;
    ngnt = 0;
    foreach (order[k]) begin
      if (elig[order[k]]) begin
        g = '0;
        g[order[k]] = 1'b1;
        gnt_q.push_back(g);
        ngnt++;
      end
    end
    ee.nd = v.nodata;
    ee.ne = v.noend;
    err_q.push_back(ee);
    done_at  = v.done_at;
    bus.ACT  = v.act;
    bus.KILL = v.kill;
    bus.RDY  = v.rdy;
    bus.START = 1'b1;
    n = 0;
    got = 0;
    while (n < v.len + 20 && !got) begin
      @(posedge clk);
      #1;
      bus.START = 1'b0;
      n++;
      if (n == 1) begin
        chk($sformatf("busy_v%0d", idx), 32'(bus.BUSY), 32'h1);
        chk($sformatf("flags_clr_v%0d", idx), 32'({bus.NODATA, bus.NOEND}), 32'h0);
      end
      if (bus.EVT_DONE) got = 1;
    end
    chk($sformatf("evt_len_v%0d", idx), 32'(n), 32'(v.len));
    if (ngnt > 0)
      chk($sformatf("gnt_len_v%0d", idx), 32'(last_len), 32'((v.done_at == 0) ? 4095 : v.done_at));
    @(posedge clk);
    #1;
    chk($sformatf("idle_v%0d", idx), 32'({bus.BUSY, bus.EVT_DONE, bus.GNT}), 32'h0);
    chk($sformatf("sb_empty_v%0d", idx), 32'(gnt_q.size() + err_q.size()), 32'h0);
  endtask

  initial begin
    bit got;
    vecs[0] = '{act:7'h7F, kill:7'h00, rdy:7'h7F, done_at:3,    nodata:7'h00, noend:7'h00, len:38};
    vecs[1] = '{act:7'h03, kill:7'h00, rdy:7'h01, done_at:3,    nodata:7'h02, noend:7'h00, len:455};
    vecs[2] = '{act:7'h7F, kill:7'h20, rdy:7'h7F, done_at:2,    nodata:7'h00, noend:7'h00, len:27};
    vecs[3] = '{act:7'h7F, kill:7'h20, rdy:7'h5F, done_at:2,    nodata:7'h00, noend:7'h00, len:27};
    vecs[4] = '{act:7'h01, kill:7'h00, rdy:7'h01, done_at:1,    nodata:7'h00, noend:7'h00, len:6};
    vecs[5] = '{act:7'h7F, kill:7'h7F, rdy:7'h00, done_at:1,    nodata:7'h00, noend:7'h00, len:3};
    vecs[6] = '{act:7'h7F, kill:7'h00, rdy:7'h35, done_at:1,    nodata:7'h4A, noend:7'h00, len:462};
    vecs[7] = '{act:7'h40, kill:7'h00, rdy:7'h40, done_at:4095, nodata:7'h00, noend:7'h00, len:4100};
    vecs[8] = '{act:7'h40, kill:7'h00, rdy:7'h40, done_at:0,    nodata:7'h00, noend:7'h40, len:4100};
    vecs[9] = '{act:7'h41, kill:7'h00, rdy:7'h41, done_at:0,    nodata:7'h00, noend:7'h41, len:8197};

    rst = 1'b1;
    bus.START = 1'b0;
    bus.ACT = '0;
    bus.KILL = '0;
    bus.RDY = '0;
    #3;
    chk("reset_outputs", 32'({bus.BUSY, bus.EVT_DONE, bus.GNT, bus.NODATA, bus.NOEND}), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_event(i, vecs[i]);

    // START while busy is ignored; reset mid-XFER aborts asynchronously.
    gnt_q.push_back(7'h40);
    done_at = 0;
    bus.ACT = 7'h7F;
    bus.KILL = '0;
    bus.RDY = 7'h7F;
    bus.START = 1'b1;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    chk("noend_clr_on_start", 32'(bus.NOEND), 32'h0);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk);
      #1;
      if (bus.GNT != '0) got = 1;
    end
    chk("rst_seq_gnt", 32'(bus.GNT), 32'h40);
    bus.ACT = 7'h01;
    bus.RDY = 7'h01;
    bus.START = 1'b1;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("start_ignored", 32'({bus.BUSY, bus.GNT}), 32'hC0);
    #3;
    rst = 1'b1;
    #1;
    chk("async_abort", 32'({bus.BUSY, bus.GNT, bus.EVT_DONE}), 32'h0);
    gnt_q.delete();
    err_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'({bus.BUSY, bus.EVT_DONE, bus.GNT}), 32'h0);
    run_event(10, vecs[1]);
    run_event(11, vecs[4]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rdout_sched.md
Name: rdout_sched

Overview:
- Per-event readout scheduler in the CLKCMS domain.
- On each event start, it latches which sources are active: ALCT, TMB and CFEB1..5.
- It waits a bounded hold-off for their FIFOs to report data, then grants the shared output path to one source at a time in fixed priority.
- It times out sources that never signal end-of-block, and reports no-data and no-end error vectors for the DMB tail words.

Parameters:
- HLDOFF, 448: maximum hold-off cycles waiting for active sources to become ready.
- TMO_W, 12: width of the per-grant timeout counter; timeout fires at count 2^TMO_W-1.

Ports:
- CLKCMS  in  1  system clock, all logic on rising edge
- pop_rst  in  1  reset, asynchronous, active-high
- START  in  1  one-cycle event start pulse
- ACT  in  7  [7]=ALCT, [6]=TMB, [5:1]=CFEB5..1 DAV/active flags, sampled on START
- KILL  in  7  same bit map; killed sources are excluded, sampled on START
- RDY  in  7  source FIFO has data (active-high, level)
- DONE  in  1  end-of-block seen for the currently granted source (level or pulse)
- BUSY  out  1  event in progress
- GNT  out  7  one-hot grant to the output path; all-zero when no grant
- EVT_DONE  out  1  one-cycle pulse, event scheduling finished
- NODATA  out  7  active source never ready within hold-off
- NOEND  out  7  granted source timed out without DONE

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0; pending mask 0.
- States: IDLE, HOLD, ARB, XFER, GAP, FIN; binary-encoded.
- IDLE:
  - START=1 → load pend = ACT & ~KILL; clear NODATA and NOEND; hold counter = 0; go to HOLD.
  - BUSY=1 from the next cycle, and stays 1 in every state except IDLE.
- START is ignored in every state other than IDLE; no queueing.
- HOLD: counter increments each cycle. Exit to ARB when either condition holds:
  - (pend & ~RDY) == 0 (all pending sources ready), or
  - counter == HLDOFF-1.
- On HOLD exit, same clock edge:
  - NODATA <= pend & ~RDY
  - pend <= pend & RDY
- HOLD with pend == 0 at entry exits after 1 cycle. The path is HOLD → ARB → FIN.
- ARB (1 cycle):
  - pend == 0 → FIN.
  - Otherwise the granted source is the highest set bit of pend in the order bit7 > bit6 > bit1 > bit2 > bit3 > bit4 > bit5.
  - GNT is registered and asserted on entry to XFER; the timeout counter is cleared.
- XFER:
  - GNT held; timeout counter increments.
  - DONE=1 → clear the granted bit in pend → GAP.
  - Counter == 2^TMO_W-1 with DONE=0 → set NOEND for the granted bit; clear the pend bit → GAP.
  - DONE and timeout in the same cycle: DONE wins, NOEND is not set.
  - DONE is ignored outside XFER.
- GAP: GNT=0 for exactly 1 cycle, then ARB. This guarantees non-overlapping grants.
- FIN: EVT_DONE=1 for 1 cycle → IDLE; BUSY drops in the same cycle as the FIN→IDLE transition.
- NODATA and NOEND hold their values until the next accepted START or pop_rst.
- RDY changes after HOLD exit do not re-admit sources.
- pop_rst mid-event aborts immediately: GNT=0, BUSY=0, no EVT_DONE pulse.
- Counter widths: the hold counter is ceil(log2(HLDOFF)) bits and saturates at HLDOFF-1. The timeout counter is TMO_W bits and never wraps inside XFER.
- Minimum event length, one source ready at START with DONE in its first XFER cycle: HOLD1, ARB, XFER1, GAP, ARB, FIN = 6 cycles after START.

Test Plan:
- All ready, ordered completion:
  - Stimulus: ACT=7'h7F, KILL=0, RDY=7'h7F at START; pulse DONE 3 cycles into each grant.
  - Required: GNT sequence 0x40, 0x20, 0x01, 0x02, 0x04, 0x08, 0x10; one GAP cycle between grants; one EVT_DONE pulse; NODATA=0, NOEND=0.
- Missing data:
  - Stimulus: ACT=7'h03, RDY=7'h01 held.
  - Required: HOLD lasts 448 cycles; NODATA=7'h02; only GNT=0x01 issued.
- Timeout:
  - Stimulus: ACT=7'h40, RDY=7'h40, DONE never asserted.
  - Required: GNT=0x40 for 4095 cycles; NOEND=7'h40; EVT_DONE follows 2 cycles later (GAP, ARB→FIN).
- DONE coincident with timeout:
  - Stimulus: DONE asserted exactly at count 4095.
  - Required: NOEND stays 0.
- Kill:
  - Stimulus: ACT=7'h7F, KILL=7'h20.
  - Required: TMB is never granted and is absent from NODATA and NOEND.
- Reset and re-arm:
  - Stimulus: START ignored while BUSY; pop_rst asserted mid-XFER.
  - Required: GNT and BUSY are 0 asynchronously; the next START yields a clean event with error flags cleared.
